cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Sits directly downstream of the instruction and data caches. Multiplexes their miss-fill reads and write-through writes onto the single shared multi-cycle main memory port.
- Grants memory ownership to one cache at a time and tracks outstanding reads so that returned data is always routed to the cache that issued them.
- Lets each cache's fill FSM run unmodified: it holds req for the whole fill and sees `*_grant` as an extra stall.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data word width.
- MAX_OUT, 4, maximum outstanding reads tracked (≥ memory read latency). Counter width is clog2(MAX_OUT+1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- i_req  in  1  I-cache requests memory ownership; held for the whole fill.
- i_en  in  1  I-cache issues a read this cycle.
- i_addr  in  ADDR_W  I-cache word address.
- i_grant  out  1  I-cache owns memory.
- i_data  out  DATA_W  read data to I-cache.
- i_data_valid  out  1  i_data valid this cycle.
- d_req  in  1  D-cache requests memory ownership.
- d_en  in  1  D-cache issues an access this cycle.
- d_wr  in  1  with d_en: 1 = write, 0 = read.
- d_addr  in  ADDR_W  D-cache word address.
- d_wdata  in  DATA_W  D-cache write data.
- d_grant  out  1  D-cache owns memory.
- d_data  out  DATA_W  read data to D-cache.
- d_data_valid  out  1  d_data valid this cycle.
- mem_addr  out  ADDR_W  to memory addr.
- mem_data_in  out  DATA_W  to memory data_in.
- mem_enable  out  1  to memory enable.
- mem_wr  out  1  to memory wr.
- mem_data_out  in  DATA_W  from memory data_out.
- mem_data_valid  in  1  from memory data_valid.
- err  out  1  sticky protocol error flag.

Behaviour:
- States: IDLE, OWN_I, OWN_D, DRAIN. State register and grants are registered.
- Reset (async, any time, including mid-fill):
  - state = IDLE, i_grant = d_grant = 0, outstanding = 0, last_owner = I, err = 0.
  - All mem_* outputs are 0 while in reset.
- IDLE:
  - Only d_req → OWN_D.
  - Only i_req → OWN_I.
  - Both → the requester that is not last_owner (round-robin). This means D wins the first tie after reset.
  - Grant asserts the cycle after entry.
- OWN_x:
  - x_grant = 1.
  - mem_* are driven combinationally from x's inputs in the same cycle (zero added latency).
  - mem_enable = x_en.
  - mem_wr = d_en & d_wr. Always 0 for I.
  - mem_data_in = d_wdata. Don't-care for I.
- Leaving OWN_x:
  - When x_req drops: outstanding == 0 → IDLE; else → DRAIN.
  - last_owner = x.
  - Grant deasserts the cycle after req drops.
  - x_en issued in the same cycle that req drops is ignored and sets err.
- DRAIN:
  - No grants, mem_enable = 0.
  - Returning data still routes to last_owner.
  - Go to IDLE when outstanding reaches 0. The new arbitration happens in IDLE, so the earliest regrant is 2 cycles after drain completes.
- Outstanding counter:
  - +1 on each forwarded read (mem_enable & ~mem_wr).
  - −1 on each mem_data_valid.
  - Simultaneous issue and return → unchanged.
  - Writes are not counted.
- Read data routing:
  - mem_data_valid drives i_data_valid or d_data_valid for the current/last owner only. The other valid stays 0.
  - i_data = d_data = mem_data_out, unregistered.
- Errors (set err, sticky until reset):
  - mem_data_valid while outstanding == 0: data discarded, counter stays 0, both valids stay 0.
  - Read issued while outstanding == MAX_OUT: not forwarded (mem_enable = 0), counter unchanged.
  - x_en while x_grant == 0: not forwarded.
- Ungranted requester:
  - Its en/addr are never forwarded.
  - Its req is only observed in IDLE.

Test Plan:
- Reset, then i_req = 1 only → i_grant = 1 on cycle 2. Issue 8 reads at addr 0x0010..0x001E, step 2 → mem_addr matches each cycle. 8 i_data_valid pulses; d_data_valid stays 0; after last return and i_req = 0 → IDLE, i_grant = 0.
- i_req and d_req both rise in the same cycle after reset → d_grant first. D drops req, both re-request → i_grant next (round-robin).
- D owner issues write, addr 0x1234, data 0xBEEF → mem_enable = mem_wr = 1 the same cycle, outstanding stays 0. D drops req → IDLE directly, no DRAIN.
- D issues 3 reads, drops req after 1 return → DRAIN. Remaining 2 returns go to d_data_valid. A pending i_req is not granted until outstanding = 0, then the I grant appears 2 cycles later.
- Spurious mem_data_valid in IDLE → err = 1, no valid pulses. Fifth read with MAX_OUT = 4 outstanding → mem_enable = 0, err = 1.
- Assert rst mid-fill with 2 reads outstanding → all grants, valids and err = 0 immediately. Later late returns are discarded and set err.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Shares one multi-cycle memory port between the I-cache and D-cache, granting
// ownership round-robin and steering returned read data to the issuing cache.
module cache_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  output logic [DATA_W-1:0] i_data,
  output logic              i_data_valid,
  input  logic              d_req,
  input  logic              d_en,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_grant,
  output logic [DATA_W-1:0] d_data,
  output logic              d_data_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_enable,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_data_valid,
  output logic              err
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D, DRAIN} state_t;

  state_t             state, state_nxt;
  logic               last_d, last_d_nxt;
  logic [CNT_W-1:0]   out_cnt;
  logic               cnt_full, cnt_zero, rd_ret;
  logic               fwd, fwd_wr, fsm_err, err_set;
  logic [ADDR_W-1:0]  addr_sel;
  logic [DATA_W-1:0]  wdata_sel;
  logic               route_d;

  assign cnt_full = (out_cnt == CNT_W'(MAX_OUT));
  assign cnt_zero = (out_cnt == '0);
  // Returns with nothing outstanding are protocol errors and are dropped.
  assign rd_ret   = mem_data_valid & ~cnt_zero;

  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    fwd        = 1'b0;
    fwd_wr     = 1'b0;
    fsm_err    = 1'b0;
    addr_sel   = '0;
    wdata_sel  = '0;
    case (state)
      IDLE: begin
        // On a tie the cache that did not own memory last goes first.
        if (d_req && (!i_req || !last_d))
          state_nxt = OWN_D;
        else if (i_req)
          state_nxt = OWN_I;
      end
      OWN_I: begin
        addr_sel = i_addr;
        if (i_req) begin
          if (i_en) begin
            if (cnt_full) fsm_err = 1'b1;
            else          fwd     = 1'b1;
          end
        end else begin
          last_d_nxt = 1'b0;
          fsm_err    = i_en;
          state_nxt  = cnt_zero ? IDLE : DRAIN;
        end
      end
      OWN_D: begin
        addr_sel  = d_addr;
        wdata_sel = d_wdata;
        if (d_req) begin
          if (d_en) begin
            if (d_wr) begin
              fwd    = 1'b1;
              fwd_wr = 1'b1;
            end else if (cnt_full) begin
              fsm_err = 1'b1;
            end else begin
              fwd = 1'b1;
            end
          end
        end else begin
          last_d_nxt = 1'b1;
          fsm_err    = d_en;
          state_nxt  = cnt_zero ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_zero || (out_cnt == CNT_W'(1) && mem_data_valid))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign err_set = fsm_err
                 | (i_en & ~i_grant)
                 | (d_en & ~d_grant)
                 | (mem_data_valid & cnt_zero);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last_d  <= 1'b0;
      i_grant <= 1'b0;
      d_grant <= 1'b0;
      out_cnt <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      last_d  <= last_d_nxt;
      i_grant <= (state_nxt == OWN_I);
      d_grant <= (state_nxt == OWN_D);
      if (err_set) err <= 1'b1;
      case ({fwd & ~fwd_wr, rd_ret})
        2'b10:   out_cnt <= out_cnt + CNT_W'(1);
        2'b01:   out_cnt <= out_cnt - CNT_W'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // Memory port is forced quiet while reset is held, independent of the clock.
  assign mem_enable  = fwd & ~rst;
  assign mem_wr      = fwd_wr & ~rst;
  assign mem_addr    = rst ? '0 : addr_sel;
  assign mem_data_in = rst ? '0 : wdata_sel;

  assign route_d      = (state == OWN_D) | ((state != OWN_I) & last_d);
  assign i_data_valid = rd_ret & ~route_d;
  assign d_data_valid = rd_ret & route_d;
  assign i_data       = mem_data_out;
  assign d_data       = mem_data_out;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed cycle-by-cycle vectors for the cache/memory arbiter.
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_en, d_req, d_en, d_wr, mem_data_valid;
  logic [15:0] i_addr, d_addr, d_wdata, mem_data_out;
  logic        i_grant, i_data_valid, d_grant, d_data_valid;
  logic        mem_enable, mem_wr, err;
  logic [15:0] i_data, d_data, mem_addr, mem_data_in;

  int passed = 0;
  int total  = 0;
  int idx    = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_OUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_en(i_en), .i_addr(i_addr), .i_grant(i_grant),
    .i_data(i_data), .i_data_valid(i_data_valid),
    .d_req(d_req), .d_en(d_en), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_data(d_data), .d_data_valid(d_data_valid),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_enable(mem_enable),
    .mem_wr(mem_wr), .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
    .err(err)
  );

  // exp bits: i_grant d_grant i_valid d_valid mem_enable mem_wr err
  typedef struct packed {
    logic        rst, ir, ie;
    logic [15:0] ia;
    logic        dr, de, dw;
    logic [15:0] da, dwd;
    logic        mv;
    logic [15:0] md;
    logic [6:0]  exp;
    logic [15:0] ema;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic r, ir, ie, input logic [15:0] ia,
                             input logic dr, de, dw, input logic [15:0] da, dwd,
                             input logic mv, input logic [15:0] md,
                             input logic [6:0] exp, input logic [15:0] ema);
    vec_t t;
    t = '{rst: r, ir: ir, ie: ie, ia: ia, dr: dr, de: de, dw: dw, da: da,
          dwd: dwd, mv: mv, md: md, exp: exp, ema: ema};
    return t;
  endfunction

  // Idle-input shorthands.
  function automatic vec_t vi(input logic ir, ie, input logic [15:0] ia,
                              input logic mv, input logic [15:0] md,
                              input logic [6:0] exp, input logic [15:0] ema);
    return v(1'b0, ir, ie, ia, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, mv, md, exp, ema);
  endfunction

  function automatic vec_t vd(input logic ir, dr, de, dw, input logic [15:0] da, dwd,
                              input logic mv, input logic [15:0] md,
                              input logic [6:0] exp, input logic [15:0] ema);
    return v(1'b0, ir, 1'b0, 16'h0, dr, de, dw, da, dwd, mv, md, exp, ema);
  endfunction

  function automatic vec_t vr();
    return v(1'b1, 0, 0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 7'b0000000, 16'h0);
  endfunction

  task automatic check(input string nm, input logic ok, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (ok) passed++;
    else $display("FAIL %s #%0d got %h required %h", nm, idx, got, want);
  endtask

  task automatic apply(input vec_t t);
    logic [6:0]  act;
    logic [15:0] want_wd;
    @(negedge clk);
    rst = t.rst; i_req = t.ir; i_en = t.ie; i_addr = t.ia;
    d_req = t.dr; d_en = t.de; d_wr = t.dw; d_addr = t.da; d_wdata = t.dwd;
    mem_data_valid = t.mv; mem_data_out = t.md;
    #2;
    act = {i_grant, d_grant, i_data_valid, d_data_valid, mem_enable, mem_wr, err};
    check("ctrl", act === t.exp, {25'h0, act}, {25'h0, t.exp});
    if (t.exp[2] || t.rst)
      check("mem_addr", mem_addr === t.ema, {16'h0, mem_addr}, {16'h0, t.ema});
    if (t.exp[1] || t.rst) begin
      want_wd = t.rst ? 16'h0 : t.dwd;
      check("mem_data_in", mem_data_in === want_wd, {16'h0, mem_data_in}, {16'h0, want_wd});
    end
    if (t.exp[4]) check("i_data", i_data === t.md, {16'h0, i_data}, {16'h0, t.md});
    if (t.exp[3]) check("d_data", d_data === t.md, {16'h0, d_data}, {16'h0, t.md});
    idx++;
  endtask

  initial begin
    rst = 1'b1; i_req = 0; i_en = 0; i_addr = 0; d_req = 0; d_en = 0; d_wr = 0;
    d_addr = 0; d_wdata = 0; mem_data_valid = 0; mem_data_out = 0;

    // I-cache fill: 8 reads, memory latency 2.
    tbl.push_back(vr());
    tbl.push_back(vi(1, 0, 16'h0, 0, 16'h0, 7'b0000000, 16'h0));
    for (int k = 0; k < 8; k++) begin
      if (k < 2)
        tbl.push_back(vi(1, 1, 16'(16'h10 + 2*k), 0, 16'h0, 7'b1000100, 16'(16'h10 + 2*k)));
      else
        tbl.push_back(vi(1, 1, 16'(16'h10 + 2*k), 1, 16'(16'hA000 + k - 2),
                         7'b1010100, 16'(16'h10 + 2*k)));
    end
    tbl.push_back(vi(1, 0, 16'h0, 1, 16'hA006, 7'b1010000, 16'h0));
    tbl.push_back(vi(1, 0, 16'h0, 1, 16'hA007, 7'b1010000, 16'h0));
    tbl.push_back(vi(0, 0, 16'h0, 0, 16'h0, 7'b1000000, 16'h0));
    tbl.push_back(vi(0, 0, 16'h0, 0, 16'h0, 7'b0000000, 16'h0));

    // Tie after reset goes to D, the next tie to I.
    tbl.push_back(vr());
    tbl.push_back(vd(1, 1, 0, 0, 16'h0, 16'h0, 0, 16'h0, 7'b0000000, 16'h0));
    tbl.push_back(vd(1, 1, 0, 0, 16'h0, 16'h0, 0, 16'h0, 7'b0100000, 16'h0));
    tbl.push_back(vd(1, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 7'b0100000, 16'h0));
    tbl.push_back(vd(1, 1, 0, 0, 16'h0, 16'h0, 0, 16'h0, 7'b0000000, 16'h0));
    tbl.push_back(vd(0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 7'b1000000, 16'h0));
    tbl.push_back(vd(0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 7'b0000000, 16'h0));

    // D write is forwarded the same cycle and not counted; exit goes straight to IDLE.
    tbl.push_back(vd(0, 1, 0, 0, 16'h0, 16'h0, 0, 16'h0, 7'b0000000, 16'h0));
    tbl.push_back(vd(0, 1, 1, 1, 16'h1234, 16'hBEEF, 0, 16'h0, 7'b0100110, 16'h1234));
    tbl.push_back(vd(0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 7'b0100000, 16'h0));
    tbl.push_back(vd(1, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 7'b0000000, 16'h0));
    tbl.push_back(vd(0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 7'b1000000, 16'h0));
    tbl.push_back(vd(0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 7'b0000000, 16'h0));

    foreach (tbl[n]) apply(tbl[n]);

    // D reads three, drops req after one return; I waits for the drain.
    apply(vd(0, 1, 0, 0, 16'h0, 16'h0, 0, 16'h0, 7'b0000000, 16'h0));
    apply(vd(0, 1, 1, 0, 16'h0100, 16'h0, 0, 16'h0, 7'b0100100, 16'h0100));
    apply(vd(0, 1, 1, 0, 16'h0101, 16'h0, 0, 16'h0, 7'b0100100, 16'h0101));
    apply(vd(0, 1, 1, 0, 16'h0102, 16'h0, 0, 16'h0, 7'b0100100, 16'h0102));
    apply(vd(0, 1, 0, 0, 16'h0, 16'h0, 1, 16'hD001, 7'b0101000, 16'h0));
    apply(vd(1, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 7'b0100000, 16'h0));
    apply(vd(1, 0, 0, 0, 16'h0, 16'h0, 1, 16'hD002, 7'b0001000, 16'h0));
    apply(vd(1, 0, 0, 0, 16'h0, 16'h0, 1, 16'hD003, 7'b0001000, 16'h0));
    apply(vd(1, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 7'b0000000, 16'h0));
    apply(vd(0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 7'b1000000, 16'h0));
    apply(vd(0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 7'b0000000, 16'h0));

    // Fifth outstanding read is blocked and flags err.
    apply(vr());
    apply(vi(1, 0, 16'h0, 0, 16'h0, 7'b0000000, 16'h0));
    for (int k = 0; k < 4; k++)
      apply(vi(1, 1, 16'(16'h200 + k), 0, 16'h0, 7'b1000100, 16'(16'h200 + k)));
    apply(vi(1, 1, 16'h0204, 0, 16'h0, 7'b1000000, 16'h0));
    apply(vi(1, 0, 16'h0, 1, 16'h5555, 7'b1010001, 16'h0));
    apply(vi(1, 1, 16'h0205, 0, 16'h0, 7'b1000101, 16'h0205));

    // Spurious return in IDLE is dropped and flags err.
    apply(vr());
    apply(vi(0, 0, 16'h0, 1, 16'h6666, 7'b0000000, 16'h0));
    apply(vi(0, 0, 16'h0, 0, 16'h0, 7'b0000001, 16'h0));

    // Access from a cache without the grant is not forwarded.
    apply(vr());
    apply(vi(0, 1, 16'h0777, 0, 16'h0, 7'b0000000, 16'h0));
    apply(vi(0, 0, 16'h0, 0, 16'h0, 7'b0000001, 16'h0));

    // Reset mid-fill with two reads outstanding; late returns are errors.
    apply(vr());
    apply(vd(0, 1, 0, 0, 16'h0, 16'h0, 0, 16'h0, 7'b0000000, 16'h0));
    apply(vd(0, 1, 1, 0, 16'h0300, 16'h0, 0, 16'h0, 7'b0100100, 16'h0300));
    apply(vd(0, 1, 1, 0, 16'h0301, 16'h0, 0, 16'h0, 7'b0100100, 16'h0301));
    apply(vd(0, 1, 0, 0, 16'h0, 16'h0, 0, 16'h0, 7'b0100000, 16'h0));
    apply(v(1, 0, 0, 16'h0, 1, 1, 0, 16'h0302, 16'h0, 0, 16'h0, 7'b0000000, 16'h0));
    apply(vd(0, 0, 0, 0, 16'h0, 16'h0, 1, 16'h7777, 7'b0000000, 16'h0));
    apply(vd(0, 0, 0, 0, 16'h0, 16'h0, 1, 16'h7778, 7'b0000001, 16'h0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
